// File: rtl/fact_sched_pkg.sv
// Shared types and defaults for the factorial-accelerator scheduler.
//   - default widths and limits for fact_sched parameters
//   - requester indices (CPU path / GPIO switch path)
//   - FSM state encodings and a one-hot requester helper
package fact_sched_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned N_W_DEF    = 4;
  localparam int unsigned MAX_N_DEF  = 12;
  localparam int unsigned TO_CYC_DEF = 255;
  localparam int unsigned TO_W_DEF   = 8;

  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_SW  = 1;

  localparam int unsigned ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_RESP   = 3'd3;
  localparam logic [2:0] ST_REJECT = 3'd4;

  // One-hot requester mask from a requester index.
  function automatic logic [1:0] req_onehot(input logic idx);
    logic [1:0] oh;
    oh          = 2'b00;
    oh[REQ_SW]  = idx;
    oh[REQ_CPU] = ~idx;
    return oh;
  endfunction

endpackage

// File: rtl/fact_rr_pick.sv
// Two-way round-robin selector.
//   req_valid  : request bits, one per requester
//   last_grant : requester served most recently
//   grant_idx  : requester to serve now (valid when any_req)
//   any_req    : at least one request pending
module fact_rr_pick
  import fact_sched_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant_idx,
  output logic       any_req
);

  // Lone requester wins outright; on contention the one not served last wins.
  always_comb begin
    any_req = |req_valid;
    case (req_valid)
      2'b01:   grant_idx = 1'(REQ_CPU);
      2'b10:   grant_idx = 1'(REQ_SW);
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'(REQ_CPU);
    endcase
  end

endmodule

// File: rtl/fact_sched.sv
// Scheduler sharing one factorial core between the CPU path (requester 0)
// and the GPIO switch path (requester 1).
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : per-requester request; req_n0/req_n1 operands
//   req_ready    : accept pulse, same cycle as the granting req_valid
//   rsp_valid    : per-requester response pulse
//   rsp_data/err : result and error flag, held until the next response
//   busy         : high whenever a request is in flight
//   fc_go/fc_n   : core start pulse and operand
//   fc_done/err  : core completion / error, fc_result core result
module fact_sched
  import fact_sched_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N_W    = N_W_DEF,
  parameter int unsigned MAX_N  = MAX_N_DEF,
  parameter int unsigned TO_CYC = TO_CYC_DEF,
  parameter int unsigned TO_W   = TO_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [N_W-1:0]    req_n0,
  input  logic [N_W-1:0]    req_n1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              fc_go,
  output logic [N_W-1:0]    fc_n,
  input  logic              fc_done,
  input  logic              fc_err,
  input  logic [DATA_W-1:0] fc_result
);

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic [1:0]        rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              rsp_err_d;
  logic              busy_d;
  logic              fc_go_d;
  logic [N_W-1:0]    fc_n_d;
  logic              to_resp;

  logic              pick_idx;
  logic              any_req;
  logic [N_W-1:0]    pick_n;

  fact_rr_pick u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant_idx  (pick_idx),
    .any_req    (any_req)
  );

  assign pick_n = pick_idx ? req_n1 : req_n0;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
      rsp_valid    <= 2'b00;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      fc_go        <= 1'b0;
      fc_n         <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      rsp_valid    <= rsp_valid_d;
      rsp_data     <= rsp_data_d;
      rsp_err      <= rsp_err_d;
      busy         <= busy_d;
      fc_go        <= fc_go_d;
      fc_n         <= fc_n_d;
    end
  end

  // Next-state and output logic. Pulses (fc_go, rsp_valid) are set on the
  // transition into the state that owns them, so they appear in that state.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    rsp_valid_d  = 2'b00;
    rsp_data_d   = rsp_data;
    rsp_err_d    = rsp_err;
    fc_go_d      = 1'b0;
    fc_n_d       = fc_n;
    req_ready    = 2'b00;
    to_resp      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          req_ready = req_onehot(pick_idx);
          grant_d   = pick_idx;
          if (pick_n > N_W'(MAX_N)) begin
            state_d = ST_REJECT;
          end else begin
            state_d = ST_LAUNCH;
            fc_go_d = 1'b1;
            fc_n_d  = pick_n;
          end
        end
      end

      ST_LAUNCH: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // Saturate so a stuck counter can never wrap into a false timeout.
        timer_d = (timer_q == TO_W'(TO_CYC)) ? timer_q : timer_q + TO_W'(1);
        if (fc_err) begin
          to_resp    = 1'b1;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else if (fc_done) begin
          to_resp    = 1'b1;
          rsp_err_d  = 1'b0;
          rsp_data_d = fc_result;
        end else if (timer_q == TO_W'(TO_CYC - 1)) begin
          to_resp    = 1'b1;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end
      end

      ST_REJECT: begin
        to_resp    = 1'b1;
        rsp_err_d  = 1'b1;
        rsp_data_d = '0;
      end

      ST_RESP: begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (to_resp) begin
      state_d     = ST_RESP;
      rsp_valid_d = req_onehot(grant_q);
    end

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_fact_sched.sv
module tb_fact_sched;

  localparam int M_OK     = 0;
  localparam int M_ERR    = 1;
  localparam int M_BOTH   = 2;
  localparam int M_SILENT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [3:0]  req_n0, req_n1;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err, busy, fc_go;
  logic [3:0]  fc_n;
  logic        fc_done, fc_err;
  logic [31:0] fc_result;

  fact_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_n0(req_n0), .req_n1(req_n1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .fc_go(fc_go), .fc_n(fc_n), .fc_done(fc_done), .fc_err(fc_err),
    .fc_result(fc_result)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int t = 0;

  // transaction-level reference model
  bit          busy_m;
  bit          m_idx;
  int          m_n, m_go, m_rsp, m_mode, m_lat;
  bit          m_last;
  logic [31:0] m_data, m_data_hold;
  bit          m_err, m_err_hold;

  // stimulus configuration
  bit cfg_rand, noise;
  int cfg_mode, cfg_lat;

  // behavioural factorial core
  bit c_armed;
  int c_cnt, c_mode, c_n;

  // observations for directed checks
  logic [1:0]  og[$];
  logic [31:0] od[$];
  logic        oe[$];
  int last_acc_t, last_go_t, last_rsp_t;

  function automatic logic [31:0] fact(input int n);
    longint r = 1;
    for (int i = 2; i <= n; i++) r = r * i;
    return 32'(r);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, t);
    end
  endtask

  // One clock cycle: drive core inputs, check at negedge, return just after next posedge.
  task automatic cyc();
    logic [1:0] exp_ready, exp_rv;
    bit rst_now, pick;
    int n, r;
    fc_done = 1'b0;
    fc_err = 1'b0;
    fc_result = $urandom;
    if (c_armed) begin
      if (c_mode != M_SILENT) begin
        if (c_cnt <= 1) begin
          c_armed = 1'b0;
          if (c_mode == M_OK)   begin fc_done = 1'b1; fc_result = fact(c_n); end
          if (c_mode == M_ERR)  fc_err = 1'b1;
          if (c_mode == M_BOTH) begin fc_done = 1'b1; fc_err = 1'b1; fc_result = fact(c_n); end
        end else c_cnt--;
      end
    end else if (noise && $urandom_range(0, 2) == 0) begin
      fc_done = 1'($urandom);
      fc_err = 1'($urandom);
    end
    rst_now = rst;

    @(negedge clk);
    exp_ready = 2'b00;
    exp_rv = 2'b00;
    chk("busy", 64'(busy), 64'(busy_m));
    if (!busy_m && req_valid != 2'b00) begin
      pick = (req_valid == 2'b11) ? ~m_last : req_valid[1];
      exp_ready = pick ? 2'b10 : 2'b01;
      n = pick ? int'(req_n1) : int'(req_n0);
      busy_m = 1'b1;
      m_idx = pick;
      m_n = n;
      if (cfg_rand) begin
        r = $urandom_range(0, 99);
        m_mode = (r < 80) ? M_OK : (r < 88) ? M_ERR : (r < 97) ? M_BOTH : M_SILENT;
        m_lat = $urandom_range(1, 12);
      end else begin
        m_mode = cfg_mode;
        m_lat = cfg_lat;
      end
      if (n > 12) begin
        m_go = -1; m_rsp = t + 2; m_data = 32'd0; m_err = 1'b1;
      end else begin
        m_go = t + 1;
        m_rsp = (m_mode == M_SILENT) ? m_go + 256 : m_go + m_lat + 1;
        m_data = (m_mode == M_OK) ? fact(n) : 32'd0;
        m_err = (m_mode != M_OK);
      end
    end
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("fc_go", 64'(fc_go), 64'(busy_m && t == m_go));
    if (busy_m && m_go >= 0 && t >= m_go && t < m_rsp) chk("fc_n", 64'(fc_n), 64'(m_n));
    if (busy_m && t == m_rsp) begin
      exp_rv = m_idx ? 2'b10 : 2'b01;
      m_data_hold = m_data;
      m_err_hold = m_err;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("rsp_data", 64'(rsp_data), 64'(m_data_hold));
    chk("rsp_err", 64'(rsp_err), 64'(m_err_hold));
    if (exp_rv != 2'b00) begin m_last = m_idx; busy_m = 1'b0; end

    if (req_ready != 2'b00) begin og.push_back(req_ready); last_acc_t = t; end
    if (fc_go) begin
      c_armed = 1'b1; c_mode = m_mode; c_cnt = m_lat; c_n = int'(fc_n); last_go_t = t;
    end
    if (rsp_valid != 2'b00) begin
      c_armed = 1'b0; od.push_back(rsp_data); oe.push_back(rsp_err); last_rsp_t = t;
    end
    t++;

    @(posedge clk);
    #1;
    if (rst_now) begin
      busy_m = 1'b0; m_last = 1'b1; m_data_hold = 32'd0; m_err_hold = 1'b0; c_armed = 1'b0;
    end
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  task automatic clear_obs();
    og.delete(); od.delete(); oe.delete();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_fc_go"}, 64'(fc_go), 64'd0);
    chk({tag, "_fc_n"}, 64'(fc_n), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_n0 = 4'd0; req_n1 = 4'd0;
    fc_done = 1'b0; fc_err = 1'b0; fc_result = 32'd0;
    busy_m = 1'b0; m_last = 1'b1; m_data_hold = 32'd0; m_err_hold = 1'b0;
    m_go = -1; m_rsp = -1; m_idx = 1'b0; m_n = 0; m_mode = M_OK; m_lat = 1; m_data = 32'd0; m_err = 1'b0;
    cfg_rand = 1'b0; noise = 1'b0; cfg_mode = M_OK; cfg_lat = 1;
    c_armed = 1'b0; c_cnt = 0; c_mode = M_OK; c_n = 0;
    last_acc_t = 0; last_go_t = 0; last_rsp_t = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_idle_outputs("reset");

    // single request, core answers 10 cycles after go
    clear_obs();
    cfg_mode = M_OK; cfg_lat = 10;
    req_valid = 2'b01; req_n0 = 4'd5;
    cyc();
    req_valid = 2'b00;
    run(14);
    chk("single_grant", 64'(og.size() > 0 ? og[0] : 2'b00), 64'(2'b01));
    chk("single_go_lat", 64'(last_go_t - last_acc_t), 64'd1);
    chk("single_rsp_lat", 64'(last_rsp_t - last_go_t), 64'd11);
    chk("single_data", 64'(od.size() > 0 ? od[0] : 32'hx), 64'd120);

    // largest legal operand from requester 1
    clear_obs();
    cfg_lat = 3;
    req_valid = 2'b10; req_n1 = 4'd12;
    cyc();
    req_valid = 2'b00;
    run(8);
    chk("max_n_data", 64'(od.size() > 0 ? od[0] : 32'hx), 64'h1C8CFC00);

    // rejection of n=13, spurious core strobes while not waiting
    clear_obs();
    noise = 1'b1;
    req_valid = 2'b01; req_n0 = 4'd13;
    cyc();
    req_valid = 2'b00;
    run(5);
    noise = 1'b0;
    chk("reject_lat", 64'(last_rsp_t - last_acc_t), 64'd2);
    chk("reject_err", 64'(oe.size() > 0 ? oe[0] : 1'bx), 64'd1);

    // contention from reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    clear_obs();
    cfg_mode = M_OK; cfg_lat = 2;
    req_valid = 2'b11; req_n0 = 4'd3; req_n1 = 4'd4;
    run(21);
    req_valid = 2'b00;
    run(8);
    for (int i = 0; i < 4; i++) begin
      chk("cont_grant", 64'(og.size() > i ? og[i] : 2'b00), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
      chk("cont_data", 64'(od.size() > i ? od[i] : 32'hx), 64'((i % 2 == 0) ? 6 : 24));
    end

    // done and error together, then error alone
    clear_obs();
    cfg_mode = M_BOTH; cfg_lat = 4;
    req_valid = 2'b01; req_n0 = 4'd6;
    cyc();
    req_valid = 2'b00;
    run(8);
    cfg_mode = M_ERR; cfg_lat = 1;
    req_valid = 2'b10; req_n1 = 4'd2;
    cyc();
    req_valid = 2'b00;
    run(5);
    chk("both_err", 64'(oe.size() > 0 ? oe[0] : 1'bx), 64'd1);
    chk("both_data", 64'(od.size() > 0 ? od[0] : 32'hx), 64'd0);

    // silent core times out
    clear_obs();
    cfg_mode = M_SILENT;
    req_valid = 2'b01; req_n0 = 4'd7;
    cyc();
    req_valid = 2'b00;
    run(262);
    chk("timeout_lat", 64'(last_rsp_t - last_go_t), 64'd256);
    chk("timeout_err", 64'(oe.size() > 0 ? oe[0] : 1'bx), 64'd1);

    // reset in the middle of WAIT
    clear_obs();
    req_valid = 2'b01; req_n0 = 4'd8;
    cyc();
    req_valid = 2'b00;
    run(20);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_idle_outputs("midreset");
    cfg_mode = M_OK; cfg_lat = 2;
    req_valid = 2'b11; req_n0 = 4'd4; req_n1 = 4'd1;
    cyc();
    req_valid = 2'b00;
    run(6);
    chk("midreset_rsp_cnt", 64'(od.size()), 64'd1);
    chk("midreset_grant", 64'(og.size() > 0 ? og[0] : 2'b00), 64'(2'b01));
    chk("midreset_data", 64'(od.size() > 0 ? od[0] : 32'hx), 64'd24);

    // randomized traffic
    cfg_rand = 1'b1; noise = 1'b1;
    for (int i = 0; i < 900; i++) begin
      req_valid = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
      req_n0 = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12));
      req_n1 = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12));
      cyc();
    end
    req_valid = 2'b00;
    run(300);
    chk("drain_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
